shift_memory_param: RTL and testbench

//  Parametrised tapped shift memory: successor to the fixed 8x64 shift store in the

---
 rtl/shmem_pkg.sv | 19 +
 rtl/shmem_window_sum.sv | 35 +++
 rtl/shift_memory_param.sv | 107 ++++++++++
 tb/tb_shift_memory_param.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/shmem_pkg.sv
// Shared constants and width helpers for the tapped shift memory.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package shmem_pkg;

    // Word width of the original fixed store.
    localparam int SHMEM_DEFAULT_WIDTH = 64;

    // Read-address width for a store of 'depth' stages.
    function automatic int shmem_aw(input int depth);
        return $clog2(depth);
    endfunction

    // Counter width able to hold 0..depth inclusive.
    function automatic int shmem_cw(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/shmem_window_sum.sv
// Running unsigned sum of the valid stages of the shift memory.
// Latency: sum reflects a shift on the clock edge that performs it.
// Backpressure: none; updates on every enable, holds otherwise.
//
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   enable      shift strobe of the parent store
//   add         word entering stage 0
//   drop        word leaving the last stage (already zeroed if that stage was invalid)
//   sum         running sum, SW bits wide
module shmem_window_sum
    import shmem_pkg::*;
#(
    parameter int WIDTH = SHMEM_DEFAULT_WIDTH,
    parameter int SW    = WIDTH + 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] add,
    input  logic [WIDTH-1:0] drop,
    output logic [SW-1:0]    sum
);

    // SW is sized so the sum of DEPTH full-scale words never wraps, so the
    // subtraction below can never underflow either.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum <= '0;
        end else if (enable) begin
            sum <= sum + SW'(add) - SW'(drop);
        end
    end

endmodule

// File: rtl/shift_memory_param.sv
// Parametrised tapped shift memory: last DEPTH words, per-stage valid, registered tap read.
// Latency: tap read 1 cycle (read-before-shift); fill_count/full/oldest follow the stored state.
// Backpressure: none; enable shifts unconditionally, the oldest word drops when full.
//
// Optional feature: define SHMEM_SUM_EN to add the window_sum port and accumulator.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   enable       shift strobe; inmem enters stage 0
//   inmem        input word
//   rd_addr      tap select, 0 = newest, DEPTH-1 = oldest
//   outmem       registered tap data (0 when rd_addr >= DEPTH)
//   out_valid    registered valid bit of the selected stage
//   oldest       combinational view of the last stage (meaningful when full)
//   fill_count   number of valid stages, 0..DEPTH
//   full         fill_count == DEPTH
//   window_sum   sum of the valid stages (SHMEM_SUM_EN only)
module shift_memory_param
    import shmem_pkg::*;
#(
    parameter int WIDTH = SHMEM_DEFAULT_WIDTH,
    parameter int DEPTH = 8,
    parameter int AW    = shmem_aw(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [WIDTH-1:0]  inmem,
    input  logic [AW-1:0]     rd_addr,
    output logic [WIDTH-1:0]  outmem,
    output logic              out_valid,
    output logic [WIDTH-1:0]  oldest,
    output logic [AW:0]       fill_count,
    output logic              full
`ifdef SHMEM_SUM_EN
    ,
    output logic [WIDTH+AW:0] window_sum
`endif
);

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] stage [DEPTH];
    logic [DEPTH-1:0] valid;
    logic             addr_ok;

    // With a power-of-two depth every address is in range; otherwise the
    // upper addresses must read as empty.
    if (DEPTH == (1 << AW)) begin : g_addr_pow2
        assign addr_ok = 1'b1;
    end else begin : g_addr_npow2
        assign addr_ok = ({1'b0, rd_addr} < DEPTH_C);
    end

    assign full   = (fill_count == DEPTH_C);
    assign oldest = stage[DEPTH-1];

    // The read uses the pre-edge contents, so a tap sampled on the same edge
    // as a shift returns the word that was there before the shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
            valid      <= '0;
            fill_count <= '0;
            outmem     <= '0;
            out_valid  <= 1'b0;
        end else begin
            if (enable) begin
                stage[0] <= inmem;
                for (int i = 1; i < DEPTH; i++) begin
                    stage[i] <= stage[i-1];
                end
                valid <= {valid[DEPTH-2:0], 1'b1};
                if (!full) begin
                    fill_count <= fill_count + (AW + 1)'(1);
                end
            end
            if (addr_ok) begin
                outmem    <= stage[rd_addr];
                out_valid <= valid[rd_addr];
            end else begin
                outmem    <= '0;
                out_valid <= 1'b0;
            end
        end
    end

`ifdef SHMEM_SUM_EN
    // Only a valid last stage contributes to the sum, so only it is subtracted.
    logic [WIDTH-1:0] sum_drop;
    assign sum_drop = valid[DEPTH-1] ? stage[DEPTH-1] : '0;

    shmem_window_sum #(
        .WIDTH (WIDTH),
        .SW    (WIDTH + AW + 1)
    ) u_window_sum (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .add    (inmem),
        .drop   (sum_drop),
        .sum    (window_sum)
    );
`endif

endmodule

// File: tb/tb_shift_memory_param.sv
// Scoreboard bench for shift_memory_param (DEPTH=8 and DEPTH=5 instances, WIDTH=64).
// Latency: expectations are due one cycle after the inputs are applied.
// Backpressure: none; the driver issues one step per cycle.
module tb_shift_memory_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [63:0] inmem = '0;
    logic [2:0]  rd_addr = '0;

    logic [63:0] outmem8, oldest8, outmem5, oldest5;
    logic        out_valid8, full8, out_valid5, full5;
    logic [3:0]  fill8, fill5;
`ifdef SHMEM_SUM_EN
    logic [67:0] sum8, sum5;
`endif

    always #5 clk = ~clk;

    shift_memory_param #(.WIDTH(64), .DEPTH(8)) dut8 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .inmem      (inmem),
        .rd_addr    (rd_addr),
        .outmem     (outmem8),
        .out_valid  (out_valid8),
        .oldest     (oldest8),
        .fill_count (fill8),
        .full       (full8)
`ifdef SHMEM_SUM_EN
        ,
        .window_sum (sum8)
`endif
    );

    shift_memory_param #(.WIDTH(64), .DEPTH(5)) dut5 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .inmem      (inmem),
        .rd_addr    (rd_addr),
        .outmem     (outmem5),
        .out_valid  (out_valid5),
        .oldest     (oldest5),
        .fill_count (fill5),
        .full       (full5)
`ifdef SHMEM_SUM_EN
        ,
        .window_sum (sum5)
`endif
    );

    typedef struct {
        int          cyc;
        logic [63:0] out8;
        logic        v8;
        int          fc8;
        logic [63:0] old8;
        logic [67:0] s8;
        logic [63:0] out5;
        logic        v5;
        int          fc5;
        logic [63:0] old5;
        logic [67:0] s5;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] q8[$];   // reference history, index 0 = newest
    logic [63:0] q5[$];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: each entry is due once the edge after its issue has passed.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                check("outmem8",    128'(outmem8),    128'(e.out8));
                check("out_valid8", 128'(out_valid8), 128'(e.v8));
                check("fill8",      128'(fill8),      128'(e.fc8));
                check("full8",      128'(full8),      128'(e.fc8 == 8));
                if (e.fc8 == 8) check("oldest8", 128'(oldest8), 128'(e.old8));
                check("outmem5",    128'(outmem5),    128'(e.out5));
                check("out_valid5", 128'(out_valid5), 128'(e.v5));
                check("fill5",      128'(fill5),      128'(e.fc5));
                check("full5",      128'(full5),      128'(e.fc5 == 5));
                if (e.fc5 == 5) check("oldest5", 128'(oldest5), 128'(e.old5));
`ifdef SHMEM_SUM_EN
                check("sum8", 128'(sum8), 128'(e.s8));
                check("sum5", 128'(sum5), 128'(e.s5));
`endif
            end
        end
    end

    // Driver: apply one cycle of inputs, push the expectation, advance the model.
    task automatic step(input logic rst, input logic en, input logic [63:0] din, input logic [2:0] addr);
        exp_t e;
        int   a;
        @(posedge clk);
        #1;
        reset   = rst;
        enable  = en;
        inmem   = din;
        rd_addr = addr;
        a       = int'(addr);
        e.cyc   = cyc;
        if (rst) begin
            e.out8 = '0; e.v8 = 1'b0;
            e.out5 = '0; e.v5 = 1'b0;
        end else begin
            e.v8   = (a < q8.size());
            e.out8 = e.v8 ? q8[a] : 64'd0;
            e.v5   = (a < 5) && (a < q5.size());
            e.out5 = e.v5 ? q5[a] : 64'd0;
        end
        if (rst) begin
            q8.delete();
            q5.delete();
        end else if (en) begin
            q8.push_front(din);
            if (q8.size() > 8) void'(q8.pop_back());
            q5.push_front(din);
            if (q5.size() > 5) void'(q5.pop_back());
        end
        e.fc8 = q8.size();
        e.fc5 = q5.size();
        e.old8 = (q8.size() == 8) ? q8[7] : 64'd0;
        e.old5 = (q5.size() == 5) ? q5[4] : 64'd0;
        e.s8 = '0;
        foreach (q8[i]) e.s8 += 68'(q8[i]);
        e.s5 = '0;
        foreach (q5[i]) e.s5 += 68'(q5[i]);
        sb.push_back(e);
    endtask

    initial begin
        // Reset state
        step(1'b1, 1'b0, 64'd0, 3'd0);
        step(1'b1, 1'b0, 64'd0, 3'd0);
        step(1'b0, 1'b0, 64'd0, 3'd7);

        // Fill with 1..8, then read newest and oldest
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 64'(i), 3'd0);
        step(1'b0, 1'b0, 64'd0, 3'd0);
        step(1'b0, 1'b0, 64'd0, 3'd7);

        // Reset while full and shifting: the presented word is not stored
        step(1'b1, 1'b1, 64'hDEAD_BEEF, 3'd0);
        step(1'b0, 1'b0, 64'd0, 3'd0);

        // Partial fill: invalid stage reads as 0, valid stage reads back
        step(1'b0, 1'b1, 64'd10, 3'd0);
        step(1'b0, 1'b1, 64'd20, 3'd0);
        step(1'b0, 1'b1, 64'd30, 3'd0);
        step(1'b0, 1'b0, 64'd0, 3'd5);
        step(1'b0, 1'b0, 64'd0, 3'd2);

        // Read-before-shift on the oldest tap
        step(1'b1, 1'b0, 64'd0, 3'd0);
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 64'(i), 3'd3);
        step(1'b0, 1'b1, 64'd9, 3'd7);
        step(1'b0, 1'b0, 64'd0, 3'd7);

        // Enable low for 4 cycles, out-of-range taps on the DEPTH=5 instance
        step(1'b0, 1'b0, 64'h1234, 3'd6);
        step(1'b0, 1'b0, 64'h5678, 3'd5);
        step(1'b0, 1'b0, 64'h9ABC, 3'd7);
        step(1'b0, 1'b0, 64'hDEF0, 3'd4);

        // All-ones words then a zero: exercises the wide running sum
        step(1'b1, 1'b0, 64'd0, 3'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd7);
        step(1'b0, 1'b1, 64'd0, 3'd7);
        step(1'b0, 1'b0, 64'd0, 3'd0);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            logic        r, en;
            logic [63:0] d;
            r  = ($urandom_range(0, 39) == 0);
            en = ($urandom_range(0, 99) < 60);
            d  = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            step(r, en, d, 3'($urandom_range(0, 7)));
        end
        step(1'b0, 1'b0, 64'd0, 3'd0);

        // Drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
